// File: rtl/i2s_playback_ctrl.sv
// Playback sequencer: fetches samples start_addr..end_addr from a synchronous RAM and feeds the I2S transmitter.
// Optional loop counter output is enabled with `define I2S_PLAY_LOOP_CNT_EN.
module i2s_playback_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  play,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  i2s_start,
    output logic [DATA_WIDTH-1:0] i2s_sample,
    input  logic                  i2s_inc_mem,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun,
    output logic                  cfg_err
`ifdef I2S_PLAY_LOOP_CNT_EN
    ,
    output logic [7:0]            loop_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_DRAIN} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  pending_q, pending_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  i2s_start_q, i2s_start_d;
    logic [DATA_WIDTH-1:0] sample_q, sample_d;
    logic                  done_q, done_d;
    logic                  underrun_q, underrun_d;
    logic                  cfg_err_q, cfg_err_d;
`ifdef I2S_PLAY_LOOP_CNT_EN
    logic [7:0]            loop_cnt_q, loop_cnt_d;
`endif

    logic fetch_done;

    // A read issued at edge E is captured at edge E+MEM_LATENCY+1, once cnt has run down to zero.
    assign fetch_done = pending_q && (cnt_q == 3'd0);

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block can infer a latch.
        state_d     = state_q;
        start_d     = start_q;
        end_d       = end_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        pending_d   = pending_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        i2s_start_d = i2s_start_q;
        sample_d    = sample_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        cfg_err_d   = 1'b0;
`ifdef I2S_PLAY_LOOP_CNT_EN
        loop_cnt_d  = loop_cnt_q;
`endif

        if (pending_q && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end

        if ((state_q != S_IDLE) && stop) begin
            // Abort: any in-flight read is dropped by clearing pending; the last sample is held.
            state_d     = S_IDLE;
            i2s_start_d = 1'b0;
            valid_d     = 1'b0;
            pending_d   = 1'b0;
            cnt_d       = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (play && !stop) begin
                        if (start_addr <= end_addr) begin
                            start_d    = start_addr;
                            end_d      = end_addr;
                            mem_addr_d = start_addr;
                            mem_rd_d   = 1'b1;
                            pending_d  = 1'b1;
                            cnt_d      = LAT;
                            state_d    = S_FETCH;
`ifdef I2S_PLAY_LOOP_CNT_EN
                            loop_cnt_d = 8'd0;
`endif
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (fetch_done) begin
                        sample_d    = mem_rdata;
                        valid_d     = 1'b1;
                        pending_d   = 1'b0;
                        i2s_start_d = 1'b1;
                        state_d     = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (fetch_done) begin
                        sample_d  = mem_rdata;
                        valid_d   = 1'b1;
                        pending_d = 1'b0;
                    end
                    if (i2s_inc_mem) begin
                        if (!valid_q) begin
                            // A fetch is already outstanding; let it land rather than issuing another.
                            underrun_d = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                            if (mem_addr_q != end_q) begin
                                mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                                mem_rd_d   = 1'b1;
                                pending_d  = 1'b1;
                                cnt_d      = LAT;
                            end else if (loop_en) begin
                                mem_addr_d = start_q;
                                mem_rd_d   = 1'b1;
                                pending_d  = 1'b1;
                                cnt_d      = LAT;
`ifdef I2S_PLAY_LOOP_CNT_EN
                                if (loop_cnt_q != 8'hFF) loop_cnt_d = loop_cnt_q + 8'd1;
`endif
                            end else begin
                                sample_d = '0;
                                state_d  = S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (i2s_inc_mem) begin
                        i2s_start_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            start_q     <= '0;
            end_q       <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            pending_q   <= 1'b0;
            cnt_q       <= 3'd0;
            valid_q     <= 1'b0;
            i2s_start_q <= 1'b0;
            sample_q    <= '0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
`ifdef I2S_PLAY_LOOP_CNT_EN
            loop_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            end_q       <= end_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            i2s_start_q <= i2s_start_d;
            sample_q    <= sample_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            cfg_err_q   <= cfg_err_d;
`ifdef I2S_PLAY_LOOP_CNT_EN
            loop_cnt_q  <= loop_cnt_d;
`endif
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign i2s_start  = i2s_start_q;
    assign i2s_sample = sample_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign underrun   = underrun_q;
    assign cfg_err    = cfg_err_q;
`ifdef I2S_PLAY_LOOP_CNT_EN
    assign loop_cnt   = loop_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_playback_ctrl.sv
// Directed bench for i2s_playback_ctrl: one instance with MEM_LATENCY=1, one with MEM_LATENCY=4.
// Memory content: address a holds 16'hA000 + (a - 16'h10).
module tb_i2s_playback_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A (latency 1)
    logic        a_play = 0, a_stop = 0, a_loop = 0, a_inc = 0;
    logic [15:0] a_start = 0, a_end = 0;
    logic [15:0] a_mem_addr, a_sample;
    logic [15:0] a_rdata = 16'h0;
    logic        a_mem_rd, a_i2s_start, a_busy, a_done, a_underrun, a_cfg_err;
    logic [7:0]  a_loop_cnt;

    // Instance B (latency 4)
    logic        b_play = 0, b_stop = 0, b_loop = 0, b_inc = 0;
    logic [15:0] b_start = 0, b_end = 0;
    logic [15:0] b_mem_addr, b_sample;
    logic [15:0] b_rdata = 16'h0, b_d1 = 16'h0, b_d2 = 16'h0, b_d3 = 16'h0;
    logic        b_mem_rd, b_i2s_start, b_busy, b_done, b_underrun, b_cfg_err;
    logic [7:0]  b_loop_cnt;

    i2s_playback_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .play(a_play), .stop(a_stop), .loop_en(a_loop),
        .start_addr(a_start), .end_addr(a_end), .mem_addr(a_mem_addr), .mem_rd(a_mem_rd),
        .mem_rdata(a_rdata), .i2s_start(a_i2s_start), .i2s_sample(a_sample),
        .i2s_inc_mem(a_inc), .busy(a_busy), .done(a_done), .underrun(a_underrun),
        .cfg_err(a_cfg_err)
`ifdef I2S_PLAY_LOOP_CNT_EN
        , .loop_cnt(a_loop_cnt)
`endif
    );

    i2s_playback_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_LATENCY(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .play(b_play), .stop(b_stop), .loop_en(b_loop),
        .start_addr(b_start), .end_addr(b_end), .mem_addr(b_mem_addr), .mem_rd(b_mem_rd),
        .mem_rdata(b_rdata), .i2s_start(b_i2s_start), .i2s_sample(b_sample),
        .i2s_inc_mem(b_inc), .busy(b_busy), .done(b_done), .underrun(b_underrun),
        .cfg_err(b_cfg_err)
`ifdef I2S_PLAY_LOOP_CNT_EN
        , .loop_cnt(b_loop_cnt)
`endif
    );

`ifndef I2S_PLAY_LOOP_CNT_EN
    assign a_loop_cnt = 8'd0;
    assign b_loop_cnt = 8'd0;
`endif

    function automatic logic [15:0] data_of(input logic [15:0] addr);
        return 16'hA000 + (addr - 16'h0010);
    endfunction

    // Memory models: data valid MEM_LATENCY cycles after the mem_rd cycle.
    always @(posedge clk) begin
        if (a_mem_rd) a_rdata <= data_of(a_mem_addr);
        b_d1    <= b_mem_rd ? data_of(b_mem_addr) : 16'hDEAD;
        b_d2    <= b_d1;
        b_d3    <= b_d2;
        b_rdata <= b_d3;
    end

    int a_rd_cnt = 0, a_done_cnt = 0, a_urun_cnt = 0, a_cfg_cnt = 0, a_b2b = 0;
    int b_urun_cnt = 0, b_b2b = 0;
    logic a_rd_prev = 0, b_rd_prev = 0;

    always @(negedge clk) begin
        if (a_mem_rd) a_rd_cnt++;
        if (a_done) a_done_cnt++;
        if (a_underrun) a_urun_cnt++;
        if (a_cfg_err) a_cfg_cnt++;
        if (a_mem_rd && a_rd_prev) a_b2b++;
        if (b_underrun) b_urun_cnt++;
        if (b_mem_rd && b_rd_prev) b_b2b++;
        a_rd_prev = a_mem_rd;
        b_rd_prev = b_mem_rd;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_frame(input logic [15:0] exp_sample, input string tag);
        check(tag, a_sample, exp_sample);
        a_inc = 1'b1;
        tick();
        a_inc = 1'b0;
        tick();
        tick();
        tick();
    endtask

    logic [15:0] loop_seq [10];
    int rd_snap;

    initial begin
        loop_seq = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA000,
                     16'hA001, 16'hA002, 16'hA003, 16'hA000, 16'hA001};

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", a_busy, 0);
        check("rst_mem_rd", a_mem_rd, 0);
        check("rst_i2s_start", a_i2s_start, 0);
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_sample", a_sample, 0);
        check("rst_flags", {a_done, a_underrun, a_cfg_err}, 0);
        #10 rst_n = 1'b1;
        tick();

        // Single pass, no loop
        a_start = 16'h0010; a_end = 16'h0013; a_loop = 0; a_play = 1;
        tick();
        a_play = 0;
        check("play_mem_rd", a_mem_rd, 1);
        check("play_mem_addr", a_mem_addr, 16'h0010);
        check("play_busy", a_busy, 1);
        check("play_start_early", a_i2s_start, 0);
        tick();
        check("rd_single_cycle", a_mem_rd, 0);
        check("start_not_yet", a_i2s_start, 0);
        tick();
        check("start_rise", a_i2s_start, 1);
        a_frame(16'hA000, "pass_s0");
        a_frame(16'hA001, "pass_s1");
        a_frame(16'hA002, "pass_s2");
        a_frame(16'hA003, "pass_s3");
        check("silence_frame", a_sample, 16'h0000);
        check("drain_start_held", a_i2s_start, 1);
        check("drain_busy", a_busy, 1);
        check("pass_rd_count", a_rd_cnt, 4);
        a_inc = 1;
        tick();
        a_inc = 0;
        check("end_start_fall", a_i2s_start, 0);
        check("end_done", a_done, 1);
        check("end_idle", a_busy, 0);
        tick();
        check("done_one_cycle", a_done, 0);
        check("done_count", a_done_cnt, 1);
        check("pass_no_underrun", a_urun_cnt, 0);

        // Looped playback for 10 frames
        a_loop = 1; a_play = 1;
        tick();
        a_play = 0;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            a_frame(loop_seq[i], "loop_sample");
            if (i == 3) check("wrap_addr", a_mem_addr, 16'h0010);
        end
`ifdef I2S_PLAY_LOOP_CNT_EN
        check("loop_cnt", a_loop_cnt, 2);
`endif
        check("loop_no_underrun", a_urun_cnt, 0);
        a_stop = 1;
        tick();
        a_stop = 0;
        a_loop = 0;
        check("loop_stop_busy", a_busy, 0);
        check("loop_stop_start", a_i2s_start, 0);

        // Stop after the second inc_mem
        a_play = 1;
        tick();
        a_play = 0;
        tick();
        tick();
        a_frame(16'hA000, "stop_s0");
        check("stop_s1_pre", a_sample, 16'hA001);
        a_inc = 1;
        tick();
        a_inc = 0;
        a_stop = 1;
        tick();
        a_stop = 0;
        check("stop_start", a_i2s_start, 0);
        check("stop_busy", a_busy, 0);
        check("stop_mem_rd", a_mem_rd, 0);
        rd_snap = a_rd_cnt;
        tick();
        tick();
        tick();
        check("stop_no_rd", a_rd_cnt, rd_snap);
        check("stop_sample_held", a_sample, 16'hA001);
        check("stop_no_done", a_done_cnt, 1);

        // Rejected configuration, then play+stop collision
        a_start = 16'h0020; a_end = 16'h001F; a_play = 1;
        rd_snap = a_rd_cnt;
        tick();
        a_play = 0;
        check("cfg_err_pulse", a_cfg_err, 1);
        check("cfg_busy", a_busy, 0);
        check("cfg_mem_rd", a_mem_rd, 0);
        tick();
        check("cfg_err_one_cycle", a_cfg_err, 0);
        check("cfg_err_count", a_cfg_cnt, 1);
        check("cfg_no_rd", a_rd_cnt, rd_snap);
        a_start = 16'h0010; a_end = 16'h0013; a_play = 1; a_stop = 1;
        tick();
        a_play = 0; a_stop = 0;
        check("play_stop_busy", a_busy, 0);
        check("play_stop_rd", a_mem_rd, 0);

        // Latency 4 with strobes two cycles apart
        b_start = 16'h0010; b_end = 16'h0013; b_play = 1;
        tick();
        b_play = 0;
        tick(); tick(); tick(); tick();
        check("lat4_start_early", b_i2s_start, 0);
        tick();
        check("lat4_start_rise", b_i2s_start, 1);
        check("lat4_s0", b_sample, 16'hA000);
        b_inc = 1;
        tick();
        b_inc = 0;
        check("lat4_addr1", b_mem_addr, 16'h0011);
        tick();
        b_inc = 1;
        tick();
        b_inc = 0;
        check("lat4_underrun", b_underrun, 1);
        check("lat4_stale", b_sample, 16'hA000);
        tick(); tick(); tick();
        check("lat4_s1", b_sample, 16'hA001);
        check("lat4_urun_count", b_urun_cnt, 1);
        b_inc = 1;
        tick();
        b_inc = 0;
        check("lat4_addr2", b_mem_addr, 16'h0012);
        check("lat4_no_urun", b_underrun, 0);
        tick(); tick(); tick(); tick(); tick();
        check("lat4_s2", b_sample, 16'hA002);
        check("lat4_urun_total", b_urun_cnt, 1);
        check("rd_b2b_a", a_b2b, 0);
        check("rd_b2b_b", b_b2b, 0);

        // Reset during PLAY, then restart from a new buffer
        a_start = 16'h0010; a_end = 16'h0013; a_play = 1;
        tick();
        a_play = 0;
        tick();
        tick();
        check("pre_reset_playing", a_i2s_start, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_start", a_i2s_start, 0);
        check("arst_busy", a_busy, 0);
        check("arst_addr", a_mem_addr, 0);
        check("arst_sample", a_sample, 0);
        #1 rst_n = 1'b1;
        tick();
        a_start = 16'h0030; a_end = 16'h0031; a_play = 1;
        tick();
        a_play = 0;
        check("restart_addr", a_mem_addr, 16'h0030);
        tick();
        tick();
        check("restart_sample", a_sample, 16'hA020);
        check("restart_start", a_i2s_start, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
